mario_motion: RTL and testbench



---
 rtl/mario_motion.sv | 139 +++++++++++++
 tb/tb_mario_motion.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_motion.sv
// Per-frame sprite position controller: samples the keycode once per video frame,
// walks left/right with edge clamping and runs a ground/rise/fall jump with gravity.
module mario_motion #(
  parameter int X_START   = 320,
  parameter int GROUND_Y  = 400,
  parameter int Y_MIN     = 0,
  parameter int X_MIN     = 0,
  parameter int X_MAX     = 639,
  parameter int SIZE      = 8,
  parameter int X_STEP    = 2,
  parameter int JUMP_V    = 12,
  parameter int GRAVITY   = 1,
  parameter int VMAX_FALL = 8
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       vs,
  input  logic [7:0] keycode,
  output logic [9:0] MarioX,
  output logic [9:0] MarioY,
  output logic [9:0] Mario_size,
  output logic       facing_left,
  output logic       airborne
);

  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_W = 8'h1A;

  localparam logic signed [10:0] X_LO    = 11'(X_MIN + SIZE);
  localparam logic signed [10:0] X_HI    = 11'(X_MAX - SIZE);
  localparam logic signed [10:0] Y_TOP   = 11'(Y_MIN + SIZE);
  localparam logic signed [10:0] Y_GND   = 11'(GROUND_Y);
  localparam logic signed [10:0] X_STEPS = 11'(X_STEP);
  localparam logic signed [10:0] JUMP_S  = 11'(JUMP_V);
  localparam logic signed [6:0]  JUMP_VY = 7'(JUMP_V);
  localparam logic signed [6:0]  GRAV_VY = 7'(GRAVITY);
  localparam logic signed [6:0]  VMAX_VY = 7'(VMAX_FALL);

  typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

  state_t             state;
  logic signed [6:0]  vy;
  logic               vs_s1, vs_s2, vs_d;
  logic               tick;

  logic signed [10:0] x_s, y_s, x_try, x_new;
  logic signed [6:0]  vy_inc, vy_fall;
  logic signed [10:0] vy_inc_w, vy_fall_w, y_rise, y_fall;

  assign Mario_size = 10'(SIZE);
  assign tick       = vs_s2 & ~vs_d;

  // Next-position arithmetic in signed 11 bits so nothing wraps below zero.
  always_comb begin
    x_s = {1'b0, MarioX};
    y_s = {1'b0, MarioY};
    case (keycode)
      KEY_A:   x_try = x_s - X_STEPS;
      KEY_D:   x_try = x_s + X_STEPS;
      default: x_try = x_s;
    endcase
    if (x_try < X_LO)      x_new = X_LO;
    else if (x_try > X_HI) x_new = X_HI;
    else                   x_new = x_try;

    vy_inc    = vy + GRAV_VY;
    vy_fall   = (vy_inc > VMAX_VY) ? VMAX_VY : vy_inc;
    vy_inc_w  = {{4{vy_inc[6]}}, vy_inc};
    vy_fall_w = {{4{vy_fall[6]}}, vy_fall};
    y_rise    = y_s + vy_inc_w;
    y_fall    = y_s + vy_fall_w;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      vs_s1       <= 1'b0;
      vs_s2       <= 1'b0;
      vs_d        <= 1'b0;
      MarioX      <= 10'(X_START);
      MarioY      <= 10'(GROUND_Y);
      vy          <= '0;
      state       <= GROUND;
      facing_left <= 1'b0;
      airborne    <= 1'b0;
    end else begin
      vs_s1 <= vs;
      vs_s2 <= vs_s1;
      vs_d  <= vs_s2;
      if (tick) begin
        MarioX <= x_new[9:0];
        if (keycode == KEY_A)      facing_left <= 1'b1;
        else if (keycode == KEY_D) facing_left <= 1'b0;

        case (state)
          GROUND: begin
            if (keycode == KEY_W) begin
              vy       <= -JUMP_VY;
              MarioY   <= 10'(Y_GND - JUMP_S);
              state    <= RISE;
              airborne <= 1'b1;
            end else begin
              vy     <= '0;
              MarioY <= 10'(GROUND_Y);
            end
          end
          RISE: begin
            // Ceiling bump kills upward speed and starts the fall at once.
            if (y_rise < Y_TOP) begin
              MarioY <= Y_TOP[9:0];
              vy     <= '0;
              state  <= FALL;
            end else begin
              MarioY <= y_rise[9:0];
              vy     <= vy_inc;
              if (!vy_inc[6]) state <= FALL;
            end
          end
          FALL: begin
            if (y_fall >= Y_GND) begin
              MarioY   <= 10'(GROUND_Y);
              vy       <= '0;
              state    <= GROUND;
              airborne <= 1'b0;
            end else begin
              MarioY <= y_fall[9:0];
              vy     <= vy_fall;
            end
          end
          default: begin
            state    <= GROUND;
            airborne <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mario_motion.sv
// Self-checking bench for mario_motion: per-frame reference model of walk/jump physics,
// directed boundary scenarios and randomized keycode frames.
module tb_mario_motion;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       vs;
  logic [7:0] keycode;

  logic [9:0] mx, my, msz, cx, cy, csz;
  logic       mfl, mair, cfl, cair;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int x;
    int y;
    int vy;
    bit air;
    bit fl;
  } mstate_t;

  mstate_t ms, cs;

  localparam int CEIL_YMIN = 330;

  always #5 Clk = ~Clk;

  mario_motion u_main (
    .Clk(Clk), .Reset(Reset), .vs(vs), .keycode(keycode),
    .MarioX(mx), .MarioY(my), .Mario_size(msz),
    .facing_left(mfl), .airborne(mair)
  );

  mario_motion #(.Y_MIN(CEIL_YMIN)) u_ceil (
    .Clk(Clk), .Reset(Reset), .vs(vs), .keycode(keycode),
    .MarioX(cx), .MarioY(cy), .Mario_size(csz),
    .facing_left(cfl), .airborne(cair)
  );

  function automatic mstate_t reset_state();
    mstate_t s;
    s.x = 320; s.y = 400; s.vy = 0; s.air = 1'b0; s.fl = 1'b0;
    return s;
  endfunction

  // One frame of the physics rules; rising is simply "airborne with upward speed".
  function automatic mstate_t step(input mstate_t s, input logic [7:0] k, input int ymin);
    mstate_t n;
    int nv, ny;
    n = s;
    if (k == 8'h04) begin n.x = s.x - 2; n.fl = 1'b1; end
    else if (k == 8'h07) begin n.x = s.x + 2; n.fl = 1'b0; end
    if (n.x < 8)   n.x = 8;
    if (n.x > 631) n.x = 631;
    if (!s.air) begin
      if (k == 8'h1A) begin n.vy = -12; n.y = s.y - 12; n.air = 1'b1; end
    end else if (s.vy < 0) begin
      nv = s.vy + 1;
      ny = s.y + nv;
      if (ny < ymin + 8) begin n.y = ymin + 8; n.vy = 0; end
      else begin n.y = ny; n.vy = nv; end
    end else begin
      nv = (s.vy + 1 > 8) ? 8 : s.vy + 1;
      ny = s.y + nv;
      if (ny >= 400) begin n.y = 400; n.vy = 0; n.air = 1'b0; end
      else begin n.y = ny; n.vy = nv; end
    end
    return n;
  endfunction

  task automatic apply_reset();
    @(negedge Clk);
    Reset = 1'b1; vs = 1'b0; keycode = 8'h00;
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    ms = reset_state();
    cs = reset_state();
  endtask

  task automatic do_frame(input logic [7:0] k);
    @(negedge Clk);
    keycode = k;
    vs = 1'b1;
    repeat (4) @(negedge Clk);
    vs = 1'b0;
    repeat (4) @(negedge Clk);
    ms = step(ms, k, 0);
    cs = step(cs, k, CEIL_YMIN);
  endtask

  task automatic test_reset();
    Reset = 1'b1; vs = 1'b0; keycode = 8'h00;
    #12;
    checks++;
    if (mx !== 10'd320 || my !== 10'd400 || mfl !== 1'b0 || mair !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: x=%0d y=%0d fl=%b air=%b expected x=320 y=400 fl=0 air=0", mx, my, mfl, mair);
    end
    checks++;
    if (msz !== 10'd8 || csz !== 10'd8) begin
      failures++;
      $display("FAIL mario_size: got %0d/%0d expected 8", msz, csz);
    end
    apply_reset();
  endtask

  task automatic test_walk_latency();
    int old_x;
    apply_reset();
    for (int f = 0; f < 3; f++) begin
      old_x = ms.x;
      @(negedge Clk);
      keycode = 8'h07;
      vs = 1'b1;
      for (int e = 1; e <= 3; e++) begin
        @(posedge Clk);
        #1;
        checks++;
        if (e < 3 && mx !== 10'(old_x)) begin
          failures++;
          $display("FAIL walk_early f%0d e%0d: x=%0d expected %0d", f, e, mx, old_x);
        end else if (e == 3 && (mx !== 10'(322 + 2 * f) || mfl !== 1'b0)) begin
          failures++;
          $display("FAIL walk_edge3 f%0d: x=%0d fl=%b expected x=%0d fl=0", f, mx, mfl, 322 + 2 * f);
        end
      end
      repeat (2) @(negedge Clk);
      vs = 1'b0;
      repeat (4) @(negedge Clk);
      ms = step(ms, 8'h07, 0);
      cs = step(cs, 8'h07, CEIL_YMIN);
    end
  endtask

  task automatic test_left_clamp();
    while (ms.x > 10) do_frame(8'h04);
    for (int f = 0; f < 2; f++) begin
      do_frame(8'h04);
      checks++;
      if (mx !== 10'd8 || mfl !== 1'b1) begin
        failures++;
        $display("FAIL left_clamp f%0d: x=%0d fl=%b expected x=8 fl=1", f, mx, mfl);
      end
    end
  endtask

  task automatic test_right_clamp();
    while (ms.x < 630) do_frame(8'h07);
    for (int f = 0; f < 2; f++) begin
      do_frame(8'h07);
      checks++;
      if (mx !== 10'd631 || mfl !== 1'b0) begin
        failures++;
        $display("FAIL right_clamp f%0d: x=%0d fl=%b expected x=631 fl=0", f, mx, mfl);
      end
    end
  endtask

  task automatic run_jump(input bit hold_w, input string name);
    int exp_y[27] = '{388, 377, 367, 358, 350, 343, 337, 332, 328, 325, 323, 322, 322,
                      323, 325, 328, 332, 337, 343, 350, 358, 366, 374, 382, 390, 398, 400};
    apply_reset();
    for (int f = 0; f < 27; f++) begin
      do_frame((f == 0 || hold_w) ? 8'h1A : 8'h00);
      checks++;
      if (my !== 10'(exp_y[f]) || mair !== (f < 26) || mx !== 10'd320) begin
        failures++;
        $display("FAIL %s frame%0d: y=%0d air=%b x=%0d expected y=%0d air=%b x=320",
                 name, f + 1, my, mair, mx, exp_y[f], (f < 26));
      end
    end
  endtask

  task automatic test_jump();
    run_jump(1'b0, "jump");
    do_frame(8'h00);
    checks++;
    if (my !== 10'd400 || mair !== 1'b0) begin
      failures++;
      $display("FAIL jump_rest: y=%0d air=%b expected y=400 air=0", my, mair);
    end
  endtask

  task automatic test_hold_w();
    run_jump(1'b1, "hold_w");
    do_frame(8'h1A);
    checks++;
    if (my !== 10'd388 || mair !== 1'b1) begin
      failures++;
      $display("FAIL hold_w_rejump: y=%0d air=%b expected y=388 air=1", my, mair);
    end
  endtask

  task automatic test_reset_mid_jump();
    apply_reset();
    do_frame(8'h1A);
    for (int f = 0; f < 4; f++) do_frame(8'h00);
    checks++;
    if (my !== 10'd350 || mair !== 1'b1) begin
      failures++;
      $display("FAIL midjump_pre: y=%0d air=%b expected y=350 air=1", my, mair);
    end
    @(posedge Clk);
    #2 Reset = 1'b1;
    #1;
    checks++;
    if (mx !== 10'd320 || my !== 10'd400 || mair !== 1'b0) begin
      failures++;
      $display("FAIL midjump_async_reset: x=%0d y=%0d air=%b expected x=320 y=400 air=0", mx, my, mair);
    end
    repeat (2) @(negedge Clk);
    Reset = 1'b0;
    ms = reset_state();
    cs = reset_state();
    for (int f = 0; f < 5; f++) begin
      do_frame(8'h00);
      checks++;
      if (mx !== 10'd320 || my !== 10'd400 || mair !== 1'b0 || mfl !== 1'b0) begin
        failures++;
        $display("FAIL post_reset_idle f%0d: x=%0d y=%0d air=%b fl=%b expected 320/400/0/0", f, mx, my, mair, mfl);
      end
    end
  endtask

  task automatic test_ceiling();
    int min_y;
    int f;
    apply_reset();
    min_y = 1000;
    f = 0;
    do_frame(8'h1A);
    while (cs.air && f < 40) begin
      checks++;
      if (cy !== 10'(cs.y) || cair !== cs.air) begin
        failures++;
        $display("FAIL ceiling f%0d: y=%0d air=%b expected y=%0d air=%b", f, cy, cair, cs.y, cs.air);
      end
      if (int'(cy) < min_y) min_y = int'(cy);
      do_frame(8'h00);
      f++;
    end
    checks++;
    if (min_y != CEIL_YMIN + 8) begin
      failures++;
      $display("FAIL ceiling_apex: got %0d expected %0d", min_y, CEIL_YMIN + 8);
    end
    checks++;
    if (cy !== 10'd400 || cair !== 1'b0 || f >= 40) begin
      failures++;
      $display("FAIL ceiling_land: y=%0d air=%b frames=%0d expected y=400 air=0", cy, cair, f);
    end
  endtask

  task automatic test_random();
    logic [7:0] k;
    logic [7:0] keys[5] = '{8'h00, 8'h04, 8'h07, 8'h1A, 8'h00};
    apply_reset();
    for (int f = 0; f < 300; f++) begin
      keys[4] = 8'($urandom);
      k = keys[$urandom_range(0, 4)];
      do_frame(k);
      checks++;
      if (mx !== 10'(ms.x) || my !== 10'(ms.y) || mfl !== ms.fl || mair !== ms.air) begin
        failures++;
        $display("FAIL random_main f%0d key=%h: got %0d/%0d/%b/%b expected %0d/%0d/%b/%b",
                 f, k, mx, my, mfl, mair, ms.x, ms.y, ms.fl, ms.air);
      end
      checks++;
      if (cx !== 10'(cs.x) || cy !== 10'(cs.y) || cfl !== cs.fl || cair !== cs.air) begin
        failures++;
        $display("FAIL random_ceil f%0d key=%h: got %0d/%0d/%b/%b expected %0d/%0d/%b/%b",
                 f, k, cx, cy, cfl, cair, cs.x, cs.y, cs.fl, cs.air);
      end
    end
  endtask

  initial begin
    test_reset();
    test_walk_latency();
    test_left_clamp();
    test_right_clamp();
    test_jump();
    test_hold_w();
    test_reset_mid_jump();
    test_ceiling();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
